// File: rtl/mem_unit_queue.sv
// rtl/mem_unit_queue.sv - in-order load/store queue over a fixed-latency RAM with CDB handshake; option macro MEM_UNIT_STORE_ACK_EN
module mem_unit_queue #(
    parameter int DATA_W      = 32,
    parameter int LABEL_W     = 4,
    parameter int DEPTH       = 4,
    parameter int ADDR_W      = 8,
    parameter int MEM_LATENCY = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_op,
    input  logic [DATA_W-1:0]       in_base,
    input  logic [DATA_W-1:0]       in_offset,
    input  logic [DATA_W-1:0]       in_wdata,
    input  logic [LABEL_W-1:0]      in_label,
    output logic                    cdb_req,
    input  logic                    cdb_grant,
    output logic [LABEL_W-1:0]      cdb_label,
    output logic [DATA_W-1:0]       cdb_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    busy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT_CDB
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [PTR_W:0]       r_count;
    logic [CNT_W-1:0]     r_cnt;

    // Queue storage and RAM carry no reset; only the pointers define validity.
    logic                 r_q_op    [DEPTH];
    logic [ADDR_W-1:0]    r_q_addr  [DEPTH];
    logic [DATA_W-1:0]    r_q_wdata [DEPTH];
    logic [LABEL_W-1:0]   r_q_label [DEPTH];
    logic [DATA_W-1:0]    r_ram     [2**ADDR_W];

    logic                 w_push;
    logic                 w_pop;
    logic                 w_ram_we;
    logic                 w_cdb_load;
    logic                 w_cnt_load;
    logic                 w_cnt_dec;
    logic [ADDR_W-1:0]    w_in_addr;
    logic                 w_head_op;
    logic [ADDR_W-1:0]    w_head_addr;
    logic [DATA_W-1:0]    w_head_wdata;
    logic [LABEL_W-1:0]   w_head_label;
    logic [DATA_W-1:0]    w_cdb_value;

    assign in_ready     = (r_count != FULL_COUNT);
    assign w_push       = in_valid && in_ready;
    assign w_in_addr    = ADDR_W'(in_base + in_offset);
    assign w_head_op    = r_q_op[r_rd_ptr];
    assign w_head_addr  = r_q_addr[r_rd_ptr];
    assign w_head_wdata = r_q_wdata[r_rd_ptr];
    assign w_head_label = r_q_label[r_rd_ptr];
    // Loads broadcast the RAM word; acknowledged stores broadcast their own write data.
    assign w_cdb_value  = w_head_op ? r_ram[w_head_addr] : w_head_wdata;
    assign count        = r_count;
    assign busy         = (r_state != S_IDLE);

    // Next-state and per-cycle control strobes for the access sequencer.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_ram_we     = 1'b0;
        w_cdb_load   = 1'b0;
        w_cnt_load   = 1'b0;
        w_cnt_dec    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_state_next = S_ACCESS;
                    w_cnt_load   = 1'b1;
                end
            end
            S_ACCESS: begin
                if (r_cnt != '0) begin
                    w_cnt_dec = 1'b1;
                end else if (w_head_op) begin
                    w_cdb_load   = 1'b1;
                    w_state_next = S_WAIT_CDB;
                end else begin
                    w_ram_we = 1'b1;
`ifdef MEM_UNIT_STORE_ACK_EN
                    w_cdb_load   = 1'b1;
                    w_state_next = S_WAIT_CDB;
`else
                    w_pop        = 1'b1;
                    w_state_next = S_IDLE;
`endif
                end
            end
            S_WAIT_CDB: begin
                // cdb_req is always high here, so a grant is never seen without a request.
                if (cdb_grant) begin
                    w_pop        = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Control state: FSM, latency counter, queue pointers/occupancy and CDB result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            cdb_req   <= 1'b0;
            cdb_label <= '0;
            cdb_data  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_cnt_load) begin
                r_cnt <= CNT_W'(MEM_LATENCY - 1);
            end else if (w_cnt_dec) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (w_cdb_load) begin
                cdb_req   <= 1'b1;
                cdb_label <= w_head_label;
                cdb_data  <= w_cdb_value;
            end else if (w_pop && (r_state == S_WAIT_CDB)) begin
                cdb_req <= 1'b0;
            end
        end
    end

    // Capture an accepted request with its effective word address.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_op[r_wr_ptr]    <= in_op;
            r_q_addr[r_wr_ptr]  <= w_in_addr;
            r_q_wdata[r_wr_ptr] <= in_wdata;
            r_q_label[r_wr_ptr] <= in_label;
        end
    end

    // RAM write port; only a store reaching the end of its access writes.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_ram[w_head_addr] <= w_head_wdata;
        end
    end
endmodule

// File: tb/tb_mem_unit_queue.sv
// tb/tb_mem_unit_queue.sv - randomized self-checking bench for mem_unit_queue
module tb_mem_unit_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_op = 1'b0;
    logic [31:0] in_base = '0;
    logic [31:0] in_offset = '0;
    logic [31:0] in_wdata = '0;
    logic [3:0]  in_label = '0;
    logic        cdb_grant = 1'b0;
    logic        in_ready;
    logic        cdb_req;
    logic [3:0]  cdb_label;
    logic [31:0] cdb_data;
    logic [2:0]  count;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int cycle = 0;
    int max_count = 0;
    bit auto_grant = 1'b0;
    bit grant_rand = 1'b0;

    logic [3:0]  got_label [$];
    logic [31:0] got_data  [$];
    int          got_cycle [$];
    logic [3:0]  exp_label [$];
    logic [31:0] exp_data  [$];
    logic [31:0] mem_m [int];

    mem_unit_queue #(.DATA_W(32), .LABEL_W(4), .DEPTH(DEPTH), .ADDR_W(8), .MEM_LATENCY(10)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_base(in_base), .in_offset(in_offset), .in_wdata(in_wdata), .in_label(in_label),
        .cdb_req(cdb_req), .cdb_grant(cdb_grant), .cdb_label(cdb_label), .cdb_data(cdb_data),
        .count(count), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;
    always @(negedge clk) if (int'(count) > max_count) max_count = int'(count);

    // Background CDB arbiter: grants a pending request and logs it.
    initial forever begin
        @(posedge clk);
        #2;
        if (auto_grant) begin
            if (cdb_grant) begin
                cdb_grant = 1'b0;
            end else if (cdb_req && (!grant_rand || $urandom_range(0, 2) == 0)) begin
                cdb_grant = 1'b1;
                got_label.push_back(cdb_label);
                got_data.push_back(cdb_data);
                got_cycle.push_back(cycle);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle=%0d required=finish", cycle);
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        got_label.delete(); got_data.delete(); got_cycle.delete();
        exp_label.delete(); exp_data.delete();
    endtask

    // Drives one request until accepted and applies it to the reference memory model.
    task automatic enq(input logic op, input logic [31:0] base, input logic [31:0] off,
                       input logic [31:0] wdata, input logic [3:0] label, output int acc);
        int n;
        logic [31:0] s;
        int key;
        n = 0;
        in_valid = 1'b1; in_op = op; in_base = base; in_offset = off; in_wdata = wdata; in_label = label;
        while (!in_ready && n < 300) begin cyc(); n++; end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL enq_ready_timeout in_ready=%0b required=1", in_ready);
        end
        cyc();
        acc = cycle;
        in_valid = 1'b0;
        s = base + off;
        key = int'(s[7:0]);
        if (op) begin
            exp_label.push_back(label);
            exp_data.push_back(mem_m.exists(key) ? mem_m[key] : 32'h0);
        end else begin
            mem_m[key] = wdata;
`ifdef MEM_UNIT_STORE_ACK_EN
            exp_label.push_back(label);
            exp_data.push_back(wdata);
`endif
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (!(count == 0 && !busy && !cdb_req) && n < 3000) begin cyc(); n++; end
        checks++;
        if (!(count == 0 && !busy && !cdb_req)) begin
            failures++;
            $display("FAIL drain_timeout count=%0d busy=%0b cdb_req=%0b required=idle", count, busy, cdb_req);
        end
        repeat (2) cyc();
    endtask

    task automatic test_reset();
        cyc(); cyc();
        checks++; if (cdb_req !== 1'b0) begin failures++; $display("FAIL reset_cdb_req got=%0b exp=0", cdb_req); end
        checks++; if (cdb_label !== 4'h0) begin failures++; $display("FAIL reset_cdb_label got=%h exp=0", cdb_label); end
        checks++; if (cdb_data !== 32'h0) begin failures++; $display("FAIL reset_cdb_data got=%h exp=0", cdb_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_store_load();
        int e0, e1;
        clear_q(); auto_grant = 1'b1; grant_rand = 1'b0;
        enq(1'b0, 32'h10, 32'h4, 32'hDEADBEEF, 4'd3, e0);
        enq(1'b1, 32'h14, 32'h0, 32'h0, 4'd5, e1);
        drain();
`ifdef MEM_UNIT_STORE_ACK_EN
        checks++; if (got_label.size() != 2) begin failures++; $display("FAIL sl_cdb_count got=%0d exp=2", got_label.size()); end
        if (got_label.size() == 2) begin
            checks++; if (got_label[0] !== 4'd3 || got_data[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL sl_store_ack got=%h/%h exp=3/deadbeef", got_label[0], got_data[0]); end
            checks++; if (got_cycle[0] - e0 != 11) begin failures++; $display("FAIL sl_store_ack_latency got=%0d exp=11", got_cycle[0] - e0); end
            checks++; if (got_label[1] !== 4'd5 || got_data[1] !== 32'hDEADBEEF) begin failures++; $display("FAIL sl_load got=%h/%h exp=5/deadbeef", got_label[1], got_data[1]); end
            checks++; if (got_cycle[1] - e0 != 23) begin failures++; $display("FAIL sl_load_latency got=%0d exp=23", got_cycle[1] - e0); end
        end
`else
        checks++; if (got_label.size() != 1) begin failures++; $display("FAIL sl_cdb_count got=%0d exp=1", got_label.size()); end
        if (got_label.size() == 1) begin
            checks++; if (got_label[0] !== 4'd5 || got_data[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL sl_load got=%h/%h exp=5/deadbeef", got_label[0], got_data[0]); end
            checks++; if (got_cycle[0] - e0 != 22) begin failures++; $display("FAIL sl_load_latency got=%0d exp=22", got_cycle[0] - e0); end
        end
`endif
    endtask

    task automatic test_store_ack();
        int e;
        clear_q(); auto_grant = 1'b1; grant_rand = 1'b0;
        enq(1'b0, 32'h30, 32'h0, 32'h1234, 4'd7, e);
        drain();
`ifdef MEM_UNIT_STORE_ACK_EN
        checks++; if (got_label.size() != 1) begin failures++; $display("FAIL ack_count got=%0d exp=1", got_label.size()); end
        if (got_label.size() == 1) begin
            checks++; if (got_label[0] !== 4'd7 || got_data[0] !== 32'h1234) begin failures++; $display("FAIL ack_result got=%h/%h exp=7/1234", got_label[0], got_data[0]); end
            checks++; if (got_cycle[0] - e != 11) begin failures++; $display("FAIL ack_latency got=%0d exp=11", got_cycle[0] - e); end
        end
`else
        checks++; if (got_label.size() != 0) begin failures++; $display("FAIL silent_store_cdb got=%0d exp=0", got_label.size()); end
`endif
        clear_q();
        enq(1'b1, 32'h30, 32'h0, 32'h0, 4'd6, e);
        drain();
        checks++; if (got_label.size() != 1) begin failures++; $display("FAIL lone_load_count got=%0d exp=1", got_label.size()); end
        if (got_label.size() == 1) begin
            checks++; if (got_label[0] !== 4'd6 || got_data[0] !== 32'h1234) begin failures++; $display("FAIL lone_load got=%h/%h exp=6/1234", got_label[0], got_data[0]); end
            checks++; if (got_cycle[0] - e != 11) begin failures++; $display("FAIL lone_load_latency got=%0d exp=11", got_cycle[0] - e); end
        end
    endtask

    task automatic test_back_pressure();
        int acc [5];
        int n;
        clear_q(); auto_grant = 1'b1; grant_rand = 1'b0; max_count = 0;
        in_valid = 1'b1; in_op = 1'b1; in_base = 32'h14; in_offset = 32'h0; in_wdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            in_label = 4'(8 + i);
            n = 0;
            while (!in_ready && n < 100) begin cyc(); n++; end
            cyc();
            acc[i] = cycle;
            if (i == 3) begin
                checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready got=%0b exp=0", in_ready); end
                checks++; if (count !== 3'd4) begin failures++; $display("FAIL bp_full_count got=%0d exp=4", count); end
            end
        end
        in_valid = 1'b0;
        drain();
        checks++; if (acc[3] - acc[0] != 3) begin failures++; $display("FAIL bp_consecutive got=%0d exp=3", acc[3] - acc[0]); end
        checks++; if (acc[4] - acc[0] != 13) begin failures++; $display("FAIL bp_fifth_accept got=%0d exp=13", acc[4] - acc[0]); end
        checks++; if (max_count != 4) begin failures++; $display("FAIL bp_max_count got=%0d exp=4", max_count); end
        checks++; if (got_label.size() != 5) begin failures++; $display("FAIL bp_results got=%0d exp=5", got_label.size()); end
        for (int i = 0; i < 5 && i < got_label.size(); i++) begin
            checks++;
            if (got_label[i] !== 4'(8 + i) || got_data[i] !== 32'hDEADBEEF) begin
                failures++; $display("FAIL bp_result_%0d got=%h/%h exp=%h/deadbeef", i, got_label[i], got_data[i], 4'(8 + i));
            end
        end
    endtask

    task automatic test_delayed_grant();
        int e, n;
        clear_q(); auto_grant = 1'b0; grant_rand = 1'b0;
        enq(1'b1, 32'h14, 32'h0, 32'h0, 4'd1, e);
        enq(1'b1, 32'h30, 32'h0, 32'h0, 4'd2, e);
        repeat (3) cyc();
        cdb_grant = 1'b1; cyc(); cdb_grant = 1'b0;
        checks++; if (count !== 3'd2) begin failures++; $display("FAIL dg_stray_grant count=%0d exp=2", count); end
        n = 0;
        while (!cdb_req && n < 50) begin cyc(); n++; end
        checks++; if (cdb_req !== 1'b1 || cdb_label !== 4'd1 || cdb_data !== 32'hDEADBEEF) begin failures++; $display("FAIL dg_first got=%0b/%h/%h exp=1/1/deadbeef", cdb_req, cdb_label, cdb_data); end
        for (int i = 0; i < 7; i++) begin
            cyc();
            checks++;
            if ({cdb_req, cdb_label, cdb_data} !== {1'b1, 4'd1, 32'hDEADBEEF}) begin
                failures++; $display("FAIL dg_hold_%0d got=%0b/%h/%h exp=1/1/deadbeef", i, cdb_req, cdb_label, cdb_data);
            end
        end
        cdb_grant = 1'b1; cyc(); cdb_grant = 1'b0;
        checks++; if (cdb_req !== 1'b0) begin failures++; $display("FAIL dg_req_drop got=%0b exp=0", cdb_req); end
        checks++; if (busy !== 1'b0 || count !== 3'd1) begin failures++; $display("FAIL dg_after_grant busy=%0b count=%0d exp=0/1", busy, count); end
        cyc();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL dg_next_launch busy=%0b exp=1", busy); end
        auto_grant = 1'b1;
        drain();
        checks++; if (got_label.size() != 1) begin failures++; $display("FAIL dg_second_count got=%0d exp=1", got_label.size()); end
        if (got_label.size() == 1) begin
            checks++; if (got_label[0] !== 4'd2 || got_data[0] !== 32'h1234) begin failures++; $display("FAIL dg_second got=%h/%h exp=2/1234", got_label[0], got_data[0]); end
        end
    endtask

    task automatic test_addr_wrap();
        int e;
        clear_q(); auto_grant = 1'b1; grant_rand = 1'b0;
        enq(1'b0, 32'hFFFFFFFF, 32'h2, 32'h55, 4'd1, e);
        enq(1'b1, 32'hFFFFFFFF, 32'h2, 32'h0, 4'd2, e);
        enq(1'b1, 32'h1, 32'h0, 32'h0, 4'd3, e);
        drain();
        checks++; if (got_label.size() != exp_label.size()) begin failures++; $display("FAIL wrap_count got=%0d exp=%0d", got_label.size(), exp_label.size()); end
        for (int i = 0; i < got_label.size() && i < exp_label.size(); i++) begin
            checks++;
            if (got_label[i] !== exp_label[i] || got_data[i] !== exp_data[i]) begin
                failures++; $display("FAIL wrap_result_%0d got=%h/%h exp=%h/%h", i, got_label[i], got_data[i], exp_label[i], exp_data[i]);
            end
        end
        if (got_data.size() > 0) begin
            checks++; if (got_data[got_data.size()-1] !== 32'h55) begin failures++; $display("FAIL wrap_word1 got=%h exp=55", got_data[got_data.size()-1]); end
        end
    endtask

    task automatic test_reset_mid_access();
        int e, n;
        clear_q(); auto_grant = 1'b1; grant_rand = 1'b0;
        enq(1'b0, 32'h20, 32'h0, 32'h0, 4'd1, e);
        drain();
        clear_q();
        enq(1'b0, 32'h20, 32'h0, 32'hABCD, 4'd4, e);
        mem_m[32'h20] = 32'h0;
        repeat (5) cyc();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_pre_busy got=%0b exp=1", busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({cdb_req, busy, count, in_ready} !== {1'b0, 1'b0, 3'd0, 1'b1}) begin failures++; $display("FAIL rst_access_outputs req=%0b busy=%0b count=%0d ready=%0b exp=0/0/0/1", cdb_req, busy, count, in_ready); end
        cyc(); rst = 1'b0;
        auto_grant = 1'b0; clear_q();
        enq(1'b1, 32'h14, 32'h0, 32'h0, 4'd9, e);
        n = 0;
        while (!cdb_req && n < 50) begin cyc(); n++; end
        checks++; if (cdb_req !== 1'b1 || cdb_label !== 4'd9) begin failures++; $display("FAIL rst_wait_pre got=%0b/%h exp=1/9", cdb_req, cdb_label); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({cdb_req, cdb_label, cdb_data, busy} !== 38'h0) begin failures++; $display("FAIL rst_wait_outputs got=%0b/%h/%h/%0b exp=0/0/0/0", cdb_req, cdb_label, cdb_data, busy); end
        cyc(); rst = 1'b0;
        auto_grant = 1'b1; clear_q();
        enq(1'b1, 32'h20, 32'h0, 32'h0, 4'd5, e);
        drain();
        checks++; if (got_label.size() != 1) begin failures++; $display("FAIL rst_load_count got=%0d exp=1", got_label.size()); end
        if (got_label.size() == 1) begin
            checks++; if (got_label[0] !== 4'd5 || got_data[0] !== 32'h0) begin failures++; $display("FAIL rst_aborted_store got=%h/%h exp=5/0", got_label[0], got_data[0]); end
        end
    endtask

    task automatic test_random();
        int e;
        logic [31:0] b, tgt, d;
        logic op;
        clear_q(); auto_grant = 1'b1; grant_rand = 1'b1; max_count = 0;
        for (int w = 0; w < 8; w++) begin
            b = $urandom;
            d = $urandom;
            enq(1'b0, b, (32'h40 + 32'(w)) - b, d, 4'(w), e);
        end
        for (int i = 0; i < 60; i++) begin
            b = $urandom;
            tgt = ($urandom & 32'hFFFFFF00) | (32'h40 + 32'($urandom_range(0, 7)));
            op = 1'($urandom_range(0, 1));
            d = $urandom;
            enq(op, b, tgt - b, d, 4'($urandom_range(0, 15)), e);
            repeat ($urandom_range(0, 3)) cyc();
        end
        drain();
        grant_rand = 1'b0;
        checks++; if (got_label.size() != exp_label.size()) begin failures++; $display("FAIL rnd_count got=%0d exp=%0d", got_label.size(), exp_label.size()); end
        for (int i = 0; i < got_label.size() && i < exp_label.size(); i++) begin
            checks++;
            if (got_label[i] !== exp_label[i] || got_data[i] !== exp_data[i]) begin
                failures++; $display("FAIL rnd_result_%0d got=%h/%h exp=%h/%h", i, got_label[i], got_data[i], exp_label[i], exp_data[i]);
            end
        end
        checks++; if (max_count > DEPTH) begin failures++; $display("FAIL rnd_max_count got=%0d exp<=%0d", max_count, DEPTH); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_store_ack();
        test_back_pressure();
        test_delayed_grant();
        test_addr_wrap();
        test_reset_mid_access();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_unit_queue.md
Name: mem_unit_queue

Overview:
- Parametrised successor of the single-request memory unit in the Tomasulo datapath.
- Accepts load/store requests from reservation stations into an in-order queue of DEPTH entries. Each access is performed against an internal word-addressed RAM with a fixed MEM_LATENCY-cycle access time.
- Load results are broadcast through the CDB request/grant handshake.
- Replaces the one-outstanding-op limitation with back-pressure via in_ready.

Parameters:
- DATA_W, 32, data and operand width.
- LABEL_W, 4, reservation-station label width.
- DEPTH, 4, request queue entries; power of two, >= 2.
- ADDR_W, 8, RAM word-address bits; RAM holds 2**ADDR_W words.
- MEM_LATENCY, 10, cycles per RAM access; >= 1.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  request present this cycle.
- in_ready  out  1  queue can accept; equals !full.
- in_op  in  1  1 = load, 0 = store.
- in_base  in  DATA_W  base operand (Qj value).
- in_offset  in  DATA_W  offset operand (A).
- in_wdata  in  DATA_W  store data; ignored for loads.
- in_label  in  LABEL_W  issuing station label.
- cdb_req  out  1  result ready, requesting CDB.
- cdb_grant  in  1  CDB arbiter accepts result this cycle.
- cdb_label  out  LABEL_W  label of result.
- cdb_data  out  DATA_W  result data.
- count  out  $clog2(DEPTH)+1  occupied entries, including the entry in service.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Enqueue:
  - A request is accepted on an edge where in_valid && in_ready.
  - The stored address is (in_base + in_offset) computed at capture, modulo 2**DATA_W. Only the low ADDR_W bits select the RAM word.
- Queue:
  - Circular FIFO with read/write pointers that wrap at DEPTH.
  - Simultaneous enqueue and pop while full is not possible, because in_ready = 0.
  - Simultaneous enqueue and pop in any other state leaves count unchanged.
- FSM states: IDLE, ACCESS, WAIT_CDB.
- IDLE:
  - If count > 0 (the head entry was enqueued on an earlier edge), go to ACCESS and set cnt <= MEM_LATENCY-1.
  - A request enqueued into an empty queue therefore launches on the following edge.
- ACCESS:
  - While cnt != 0, decrement cnt.
  - When cnt == 0, a store writes RAM[addr] <= wdata, pops the entry, and returns to IDLE.
  - When cnt == 0, a load latches RAM[addr] into cdb_data and the head label into cdb_label, sets cdb_req <= 1, and goes to WAIT_CDB.
- WAIT_CDB:
  - cdb_req, cdb_label and cdb_data are held stable.
  - On an edge with cdb_grant = 1: cdb_req <= 0, pop the entry, go to IDLE.
  - cdb_grant while cdb_req = 0 is ignored.
- Latency:
  - A load enqueued at edge E into an idle, empty unit raises cdb_req after edge E+1+MEM_LATENCY. With MEM_LATENCY = 10, cdb_req rises after E+11.
  - A store enqueued under the same conditions is visible to RAM after edge E+1+MEM_LATENCY.
- Ordering: strictly in order, one RAM access at a time. A load always observes every older store.
- RAM: not reset, so contents survive rst. Contents are X until first written unless initialised by the bench.
- Reset (asynchronous, at any time including mid-ACCESS or WAIT_CDB):
  - FSM returns to IDLE; pointers, count and cnt are cleared.
  - cdb_req = 0; cdb_label = 0; cdb_data = 0; busy = 0; in_ready = 1.
  - An in-flight store aborted before its cnt == 0 edge does not write RAM.

Optional Feature:
- Macro: MEM_UNIT_STORE_ACK_EN.
- Defined: a store at cnt == 0 writes RAM, then enters WAIT_CDB with cdb_label = its label and cdb_data = wdata, and pops on grant. This lets the store's reservation station free on the CDB.
- Undefined: stores complete silently as described in Behaviour.

Test Plan:
- Store then load, MEM_LATENCY = 10:
  - Stimulus: enqueue store addr 0x10+0x4 (word 0x14), wdata 0xDEADBEEF, label 3; then load base 0x14, offset 0, label 5.
  - Response: cdb_req rises once with label 5, data 0xDEADBEEF; the store produces no CDB request.
- Back-pressure, DEPTH = 4:
  - Stimulus: enqueue 5 loads on consecutive cycles.
  - Response: in_ready = 0 after the 4th accept; the 5th is held until the first pop; count never exceeds 4.
- Delayed grant:
  - Stimulus: load completes; hold cdb_grant = 0 for 7 cycles, then pulse it once.
  - Response: cdb_req, cdb_label and cdb_data are stable all 7 cycles; cdb_req drops on the grant edge and the next entry launches on the following edge.
- Address wrap:
  - Stimulus: base 0xFFFFFFFF, offset 0x2, store 0x55, then load the same address.
  - Response: both access word 0x01; the load returns 0x55.
- Reset mid-access:
  - Stimulus: assert rst during ACCESS of a store to word 0x20 (previously 0x0), then load word 0x20.
  - Response: outputs at reset values immediately; the load returns 0x0.
- MEM_UNIT_STORE_ACK_EN defined:
  - Stimulus: store with label 7, wdata 0x1234.
  - Response: cdb_req rises after E+11 with label 7, data 0x1234, and pops on grant.
